// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared types and constants for the execute-stage ALU arbiter
package alu_share_arbiter_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_W     = $clog2(DATA_WIDTH);
  localparam int NUM_ALU_REQ = 2;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Round-robin search order: the off-th candidate when starting at ptr.
  function automatic int rr_index(input int ptr, input int off, input int n);
    return (ptr + off) % n;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational execute-stage ALU
module alu
  import alu_share_arbiter_pkg::*;
(
  input  alu_sel_e              op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, a < b};
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - combinational round-robin grant, one-hot plus index
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'(rr_index(int'(rr_ptr), i, N));
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between NUM_REQ requesters
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_ALU_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  alu_sel_e              req_op_i [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_a_i  [NUM_REQ],
  input  logic [DATA_WIDTH-1:0] req_b_i  [NUM_REQ],
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic                  busy_o
);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, id_q, grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_en, granted;
  alu_sel_e              op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, alu_result;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .enable    (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Flush wins over every handshake; RESP can hand straight back to EXEC.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: if (granted) state_d = ARB_EXEC;
        ARB_EXEC: state_d = ARB_RESP;
        ARB_RESP: if (rsp_ready_i) state_d = granted ? ARB_EXEC : ARB_IDLE;
        default:  state_d = ARB_IDLE;
      endcase
    end
  end

  // rst_n gating keeps req_ready_o low while reset is held.
  always_comb begin
    grant_en    = rst_n && !flush_i &&
                  ((state_q == ARB_IDLE) || ((state_q == ARB_RESP) && rsp_ready_i));
    req_ready_o = grant;
    granted     = |grant;
    busy_o      = (state_q != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
    end else if (granted) begin
      op_q     <= req_op_i[grant_idx];
      a_q      <= req_a_i[grant_idx];
      b_q      <= req_b_i[grant_idx];
      id_q     <= grant_idx;
      rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
    end else if (flush_i) begin
      rsp_valid_o  <= 1'b0;
    end else if (state_q == ARB_EXEC) begin
      rsp_result_o <= alu_result;
      rsp_id_o     <= id_q;
      rsp_valid_o  <= 1'b1;
    end else if ((state_q == ARB_RESP) && rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush_i;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  alu_sel_e              req_op_i [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_a_i  [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_b_i  [NUM_REQ];
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [DATA_WIDTH-1:0] rsp_result_o;
  logic                  busy_o;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] result;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Pending requests per requester, held until the model says they were taken.
  bit          pv  [NUM_REQ];
  alu_sel_e    pop [NUM_REQ];
  logic [31:0] pa  [NUM_REQ];
  logic [31:0] pb  [NUM_REQ];

  // Behavioural model of the sharing rules.
  bit                 holding  = 0;
  int                 t_avail  = 0;
  int                 rr_start = 0;
  int                 cyc      = 0;
  bit                 drv_rsp_ready = 0;
  bit                 drv_flush     = 0;
  bit                 mon_en        = 0;
  logic [NUM_REQ-1:0] exp_ready     = '0;
  bit                 exp_rsp_valid = 0;
  bit                 exp_busy      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input alu_sel_e op, input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [63:0] ext;
    sh  = int'(b[4:0]);
    ext = {{32{a[31]}}, a} >> sh;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << sh;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return ext[31:0];
      ALU_SLT:    return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      ALU_SLTU:   return {31'b0, a < b};
      ALU_PASS_B: return b;
      default:    return 32'd0;
    endcase
  endfunction

  task automatic issue(input int k, input alu_sel_e op, input logic [31:0] a, input logic [31:0] b);
    pv[k] = 1; pop[k] = op; pa[k] = a; pb[k] = b;
  endtask

  task automatic issue_rand(input int k);
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    issue(k, alu_sel_e'($urandom_range(0, 10)), a, b);
  endtask

  // One clock cycle: drive, predict, push expected response on grant, advance model.
  task automatic step();
    int gk;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid_i[i] = pv[i];
      req_op_i[i]    = pop[i];
      req_a_i[i]     = pa[i];
      req_b_i[i]     = pb[i];
    end
    rsp_ready_i   = drv_rsp_ready;
    flush_i       = drv_flush;
    exp_busy      = holding;
    exp_rsp_valid = holding && (cyc >= t_avail);
    gk = -1;
    if (!drv_flush && (!holding || (exp_rsp_valid && drv_rsp_ready))) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (gk < 0 && pv[(rr_start + n) % NUM_REQ]) gk = (rr_start + n) % NUM_REQ;
      end
    end
    exp_ready = '0;
    if (gk >= 0) begin
      exp_ready = NUM_REQ'(1) << gk;
      sb_q.push_back('{id: gk, result: ref_alu(pop[gk], pa[gk], pb[gk])});
    end
    @(posedge clk);
    if (drv_flush) begin
      holding = 0;
      sb_q.delete();
    end else if (exp_rsp_valid && drv_rsp_ready) begin
      holding = 0;
    end
    if (gk >= 0) begin
      holding  = 1;
      t_avail  = cyc + 2;
      rr_start = (gk + 1) % NUM_REQ;
      pv[gk]   = 0;
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp_valid));
      chk("busy", 64'(busy_o), 64'(exp_busy));
      if (rsp_valid_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got response id=%0d result=%0h, required none", rsp_id_o, rsp_result_o);
        end else begin
          chk("rsp_id", 64'(rsp_id_o), 64'(sb_q[0].id));
          chk("rsp_result", 64'(rsp_result_o), 64'(sb_q[0].result));
          if (rsp_ready_i && !flush_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    rsp_ready_i = 1'b0;
    req_valid_i = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pv[i] = 0; pop[i] = ALU_ADD; pa[i] = '0; pb[i] = '0;
      req_op_i[i] = ALU_ADD; req_a_i[i] = 32'd1; req_b_i[i] = 32'd2;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id_o), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result_o), 64'd0);
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // Single requester ADD 5+10.
    drv_rsp_ready = 1;
    issue(0, ALU_ADD, 32'd5, 32'd10);
    repeat (4) step();

    // Contention: SUB(10,10) then OR(4,5) back-to-back.
    issue(0, ALU_SUB, 32'd10, 32'd10);
    issue(1, ALU_OR, 32'd4, 32'd5);
    repeat (6) step();

    // Fairness with both requesters always valid.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NUM_REQ; i++) if (!pv[i]) issue_rand(i);
      step();
    end
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 0;
    repeat (3) step();

    // Backpressure on SRA(-8,2) with the other requester waiting.
    issue(0, ALU_SRA, 32'hFFFF_FFF8, 32'd2);
    step();
    drv_rsp_ready = 0;
    issue(1, ALU_ADD, 32'd7, 32'd8);
    repeat (7) step();
    drv_rsp_ready = 1;
    repeat (5) step();

    // Flush during EXEC, then SLL(4,1).
    issue(0, ALU_SLTU, 32'd3, 32'd5);
    step();
    drv_flush = 1;
    step();
    drv_flush = 0;
    repeat (2) step();
    issue(1, ALU_SLL, 32'd4, 32'd1);
    repeat (4) step();

    // Asynchronous reset while a response is held.
    drv_rsp_ready = 0;
    issue(0, ALU_XOR, 32'h55, 32'hF0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    holding  = 0;
    rr_start = 0;
    sb_q.delete();
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv_rsp_ready = 1;
    issue(1, ALU_PASS_B, 32'd10, 32'd3);
    repeat (4) step();

    // Randomized traffic with backpressure and flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) if (!pv[i] && $urandom_range(0, 1) == 1) issue_rand(i);
      drv_rsp_ready = ($urandom_range(0, 3) != 0);
      drv_flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    drv_flush = 0;
    drv_rsp_ready = 1;
    repeat (8) step();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
